ifu_fetch: RTL and testbench
============================

// Module: ifu_fetch
// PURPOSE
//  Instruction fetch stage: owns the PC, issues word fetches to instruction memory and delivers
//  {instruction, address} to the decode stage over the IF/ID interface. Producer end of the
//  ifid2id_* interface; consumes branch/jump redirects from EX and stall from pipeline control.
//  One outstanding memory request max; 1-entry skid buffer absorbs responses during stall.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC loaded on reset
//  NOP_INS    32'h0000_0013  bubble instruction (ADDI x0,x0,0) driven when no valid instr
//  TRAP_VEC   32'h0000_0100  redirect target on misaligned jump (IFU_MISALIGN_TRAP_EN only)
// PORTS
//  clk                 in   1   clock, all state on rising edge
//  rst                 in   1   synchronous reset, active-high
//  ex2if_jump_en_i     in   1   redirect request (taken branch/jump), single-cycle pulse
//  ex2if_jump_addr_i   in   32  redirect target
//  ctrl2if_stall_i     in   1   hold IF/ID output; decode not accepting
//  if2imem_req_o       out  1   fetch request
//  if2imem_addr_o      out  32  fetch address, word aligned
//  imem2if_gnt_i       in   1   request accepted this cycle
//  imem2if_rvalid_i    in   1   read data valid (>=1 cycle after gnt)
//  imem2if_rdata_i     in   32  instruction word
//  ifid2id_ins_o       out  32  instruction to decode
//  ifid2id_addr_o      out  32  PC of ifid2id_ins_o
//  ifid2id_valid_o     out  1   ins/addr hold a real instruction
//  if2ctrl_misalign_o  out  1   misaligned-redirect pulse (tied 0 without macro)
// BEHAVIOUR
//  Reset: pc=RESET_PC, state=IDLE, req_o=0, addr_o=0, ins_o=NOP_INS, addr_o(id)=0, valid_o=0,
//   skid empty, misalign_o=0. rst mid-transaction abandons it; late rvalid after rst is ignored.
//  FSM: IDLE -> REQ (next cycle after reset or when skid empty and no response pending).
//   REQ: req_o=1, addr_o=pc; req/addr held stable until gnt. gnt -> WAIT (or KILL if redirect
//   seen while in REQ). WAIT: rvalid -> deliver, pc+=4, -> REQ same-cycle re-issue allowed
//   only if skid stays empty, else IDLE. KILL: next rvalid discarded, -> REQ at new pc.
//  Deliver: if !stall, output regs <= {rdata, fetch_pc}, valid_o=1 next cycle.
//   If stall, response goes to skid; output regs hold; no new request while skid full.
//   On stall release, skid drains to output regs in 1 cycle, then fetching resumes.
//  No response and !stall: output regs <= {NOP_INS, 0}, valid_o=0 (bubble).
//  Redirect (jump_en=1): priority over stall and over a same-cycle rvalid.
//   pc <= jump_addr; skid cleared; output regs <= bubble next cycle; in WAIT -> KILL;
//   in REQ without gnt -> req_o dropped, new request at jump_addr next cycle;
//   in REQ with same-cycle gnt -> KILL.
//  Latency: gnt at N, rvalid at N+1 -> ifid2id_valid_o at N+2. Steady state 1 instr / 2 cycles
//   with 1-cycle memory. PC arithmetic 32-bit, wraps 32'hFFFF_FFFC -> 0.
// CONFIGURATION
//  IFU_MISALIGN_TRAP_EN defined: jump_addr[1:0]!=0 -> if2ctrl_misalign_o=1 for one cycle,
//   pc <= TRAP_VEC instead of jump_addr, flush as normal redirect.
//  Not defined: jump_addr[1:0] forced to 2'b00, if2ctrl_misalign_o constant 0.
// TESTING
//  Reset, 1-cycle imem returning 32'h0010_0093 @0: first req addr 0 at cycle 1; ins_o=0x00100093,
//   addr_o=0, valid_o=1 two cycles after gnt; next req addr 4.
//  Stall held 4 cycles while rvalid arrives for addr 8: output holds prior instr, no new req;
//   on release addr 8 appears exactly once, then req addr 12.
//  Redirect to 0x200 while in WAIT for addr 0x10: returned word discarded, next req 0x200,
//   valid_o=0 for flush cycle, 0x10 never delivered.
//  Redirect + stall + rvalid same cycle: redirect wins, skid cleared, next req at target.
//  gnt delayed 3 cycles: req_o and addr_o stable throughout; jump mid-REQ drops req.
//  Macro on: jump to 0x202 -> misalign_o pulses 1 cycle, next req 0x100; off: next req 0x200.

Source files
------------

// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch stage. Owns the PC, keeps at most one instruction-memory
// request outstanding, and presents {instruction, address} to decode on the ifid2id_* port.
// A one-entry skid buffer holds a response that arrives while decode is stalled.
// Optional feature macro: IFU_MISALIGN_TRAP_EN. When it is defined, a redirect to a
// non-word-aligned target raises if2ctrl_misalign_o for one cycle and vectors to TRAP_VEC.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INS  = 32'h0000_0013,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex2if_jump_en_i,
    input  logic [31:0] ex2if_jump_addr_i,
    input  logic        ctrl2if_stall_i,
    output logic        if2imem_req_o,
    output logic [31:0] if2imem_addr_o,
    input  logic        imem2if_gnt_i,
    input  logic        imem2if_rvalid_i,
    input  logic [31:0] imem2if_rdata_i,
    output logic [31:0] ifid2id_ins_o,
    output logic [31:0] ifid2id_addr_o,
    output logic        ifid2id_valid_o,
    output logic        if2ctrl_misalign_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_KILL
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic        skid_valid;
    logic [31:0] skid_ins;
    logic [31:0] skid_addr;
    logic [31:0] jump_target;
    logic        rsp_ok;

`ifdef IFU_MISALIGN_TRAP_EN
    logic jump_misalign;

    assign jump_misalign = ex2if_jump_en_i && (ex2if_jump_addr_i[1:0] != 2'b00);
    assign jump_target   = jump_misalign ? TRAP_VEC : ex2if_jump_addr_i;

    // One-cycle pulse reporting that the last redirect was misaligned
    always_ff @(posedge clk) begin
        if (rst) begin
            if2ctrl_misalign_o <= 1'b0;
        end else begin
            if2ctrl_misalign_o <= jump_misalign;
        end
    end
`else
    logic unused_trap_vec;

    assign jump_target        = ex2if_jump_addr_i & 32'hFFFF_FFFC;
    assign if2ctrl_misalign_o = 1'b0;
    assign unused_trap_vec    = ^TRAP_VEC;
`endif

    // Only a response to our own outstanding (non-killed) request is accepted
    assign rsp_ok = (state == S_WAIT) && imem2if_rvalid_i;

    // Fetch FSM, PC, skid buffer and registered IF/ID outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_IDLE;
            pc              <= RESET_PC;
            if2imem_req_o   <= 1'b0;
            if2imem_addr_o  <= '0;
            ifid2id_ins_o   <= NOP_INS;
            ifid2id_addr_o  <= '0;
            ifid2id_valid_o <= 1'b0;
            skid_valid      <= 1'b0;
            skid_ins        <= NOP_INS;
            skid_addr       <= '0;
        end else if (ex2if_jump_en_i) begin
            // Redirect beats stall and any same-cycle response: flush everything
            pc              <= jump_target;
            skid_valid      <= 1'b0;
            ifid2id_ins_o   <= NOP_INS;
            ifid2id_addr_o  <= '0;
            ifid2id_valid_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    state          <= S_REQ;
                    if2imem_req_o  <= 1'b1;
                    if2imem_addr_o <= jump_target;
                end
                S_REQ: begin
                    if2imem_req_o <= 1'b0;
                    state         <= imem2if_gnt_i ? S_KILL : S_IDLE;
                end
                default: begin
                    // A response consumed in this very cycle leaves nothing to kill
                    if (imem2if_rvalid_i) begin
                        state          <= S_REQ;
                        if2imem_req_o  <= 1'b1;
                        if2imem_addr_o <= jump_target;
                    end else begin
                        state <= S_KILL;
                    end
                end
            endcase
        end else begin
            if (!ctrl2if_stall_i) begin
                if (skid_valid) begin
                    ifid2id_ins_o   <= skid_ins;
                    ifid2id_addr_o  <= skid_addr;
                    ifid2id_valid_o <= 1'b1;
                    skid_valid      <= 1'b0;
                end else if (rsp_ok) begin
                    ifid2id_ins_o   <= imem2if_rdata_i;
                    ifid2id_addr_o  <= pc;
                    ifid2id_valid_o <= 1'b1;
                end else begin
                    ifid2id_ins_o   <= NOP_INS;
                    ifid2id_addr_o  <= '0;
                    ifid2id_valid_o <= 1'b0;
                end
            end else if (rsp_ok) begin
                skid_ins   <= imem2if_rdata_i;
                skid_addr  <= pc;
                skid_valid <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (!skid_valid) begin
                        state          <= S_REQ;
                        if2imem_req_o  <= 1'b1;
                        if2imem_addr_o <= pc;
                    end
                end
                S_REQ: begin
                    if (imem2if_gnt_i) begin
                        state         <= S_WAIT;
                        if2imem_req_o <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (imem2if_rvalid_i) begin
                        pc <= pc + 32'd4;
                        if (!ctrl2if_stall_i) begin
                            state          <= S_REQ;
                            if2imem_req_o  <= 1'b1;
                            if2imem_addr_o <= pc + 32'd4;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    if (imem2if_rvalid_i) begin
                        state          <= S_REQ;
                        if2imem_req_o  <= 1'b1;
                        if2imem_addr_o <= pc;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: directed bench for ifu_fetch with a small instruction-memory model
// (programmable grant delay and read latency).
module tb_ifu_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        jump_en;
    logic [31:0] jump_addr;
    logic        stall;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid = 1'b0;
    logic [31:0] rdata  = '0;
    logic [31:0] ins;
    logic [31:0] id_addr;
    logic        valid;
    logic        misalign;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    int unsigned gnt_lat   = 0;
    int unsigned rlat      = 0;
    int unsigned req_age   = 0;
    logic        pend      = 1'b0;
    int unsigned pend_cnt  = 0;
    logic [31:0] pend_data = '0;
    logic        bad_deliv = 1'b0;
    logic        bad_gnt   = 1'b0;
    logic [31:0] mis_tgt;

    ifu_fetch #(
        .RESET_PC (32'h0000_0000),
        .NOP_INS  (32'h0000_0013),
        .TRAP_VEC (32'h0000_0100)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .ex2if_jump_en_i    (jump_en),
        .ex2if_jump_addr_i  (jump_addr),
        .ctrl2if_stall_i    (stall),
        .if2imem_req_o      (req),
        .if2imem_addr_o     (addr),
        .imem2if_gnt_i      (gnt),
        .imem2if_rvalid_i   (rvalid),
        .imem2if_rdata_i    (rdata),
        .ifid2id_ins_o      (ins),
        .ifid2id_addr_o     (id_addr),
        .ifid2id_valid_o    (valid),
        .if2ctrl_misalign_o (misalign)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h0) ? 32'h0010_0093 : (32'hA500_0000 ^ a);
    endfunction

    assign gnt = req && (req_age >= gnt_lat);

    always_ff @(posedge clk) begin
        req_age <= (req && !gnt) ? req_age + 1 : 0;
        rvalid  <= 1'b0;
        if (pend) begin
            if (pend_cnt == 0) begin
                rvalid <= 1'b1;
                rdata  <= pend_data;
                pend   <= 1'b0;
            end else begin
                pend_cnt <= pend_cnt - 1;
            end
        end
        if (req && gnt) begin
            if (rlat == 0) begin
                rvalid <= 1'b1;
                rdata  <= mem_word(addr);
            end else begin
                pend      <= 1'b1;
                pend_cnt  <= rlat - 1;
                pend_data <= mem_word(addr);
            end
        end
    end

    always @(negedge clk) begin
        if (valid && (id_addr == 32'h10 || id_addr == 32'h204)) bad_deliv = 1'b1;
        if (req && gnt && addr == 32'h308) bad_gnt = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [31:0] a);
        check({tag, ".valid"}, 32'(valid), 32'(v));
        if (v) begin
            check({tag, ".addr"}, id_addr, a);
            check({tag, ".ins"}, ins, mem_word(a));
        end else begin
            check({tag, ".ins_nop"}, ins, 32'h0000_0013);
        end
    endtask

    task automatic check_req(input string tag, input logic r, input logic [31:0] a);
        check({tag, ".req"}, 32'(req), 32'(r));
        if (r) check({tag, ".req_addr"}, addr, a);
    endtask

    initial begin
`ifdef IFU_MISALIGN_TRAP_EN
        mis_tgt = 32'h100;
`else
        mis_tgt = 32'h200;
`endif
        rst = 1'b1; jump_en = 1'b0; jump_addr = '0; stall = 1'b0;
        tick; tick;
        check("rst.req", 32'(req), 0);
        check("rst.addr", addr, 0);
        check("rst.ins", ins, 32'h0000_0013);
        check("rst.id_addr", id_addr, 0);
        check("rst.valid", 32'(valid), 0);
        check("rst.misalign", 32'(misalign), 0);
        rst = 1'b0;

        // first fetch and latency
        tick; check_req("first", 1, 32'h0);
        tick; check_req("first_gnt", 0, 0);
        tick; check_out("first_out", 1, 32'h0); check_req("next4", 1, 32'h4);
        tick; check_out("bubble4", 0, 0);
        tick; check_out("out4", 1, 32'h4); check_req("req8", 1, 32'h8);

        // stall across the response for addr 8
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick; check_out("stall_hold", 1, 32'h4); check_req("stall_noreq", 0, 0);
        end
        stall = 1'b0;
        tick; check_out("drain8", 1, 32'h8); check_req("drain_noreq", 0, 0);
        tick; check_out("after_drain", 0, 0); check_req("req12", 1, 32'hC);
        tick; tick; check_out("out12", 1, 32'hC); check_req("req16", 1, 32'h10);

        // redirect while waiting on addr 0x10 (2-cycle read)
        rlat = 1;
        tick;
        jump_en = 1'b1; jump_addr = 32'h200;
        tick; jump_en = 1'b0; rlat = 0;
        check_out("kill_flush", 0, 0); check_req("kill_noreq", 0, 0);
        tick; check_out("kill_disc", 0, 0); check_req("req200", 1, 32'h200);
        tick; check_out("wait200", 0, 0);
        tick; check_out("out200", 1, 32'h200); check_req("req204", 1, 32'h204);

        // redirect + stall + rvalid in the same cycle
        tick;
        stall = 1'b1; jump_en = 1'b1; jump_addr = 32'h300;
        tick; jump_en = 1'b0; stall = 1'b0;
        check_out("rsr_flush", 0, 0); check_req("req300", 1, 32'h300);
        tick; check_out("rsr_skid_empty", 0, 0);
        tick; check_out("out300", 1, 32'h300); check_req("req304", 1, 32'h304);

        // delayed grant: request stable until granted
        gnt_lat = 3;
        for (int i = 0; i < 3; i++) begin
            tick; check_req("gnt_wait", 1, 32'h304);
        end
        tick; check_req("gnt_taken", 0, 0);
        tick; check_out("out304", 1, 32'h304); check_req("req308", 1, 32'h308);

        // redirect mid-REQ without grant drops the request
        jump_en = 1'b1; jump_addr = 32'h400;
        tick; jump_en = 1'b0; gnt_lat = 0;
        check_req("drop_req", 0, 0); check_out("drop_flush", 0, 0);
        tick; check_req("req400", 1, 32'h400);
        tick; tick; check_out("out400", 1, 32'h400); check_req("req404", 1, 32'h404);

        // misaligned redirect (same-cycle grant -> kill)
        jump_en = 1'b1; jump_addr = 32'h202;
        tick; jump_en = 1'b0;
`ifdef IFU_MISALIGN_TRAP_EN
        check("mis_pulse", 32'(misalign), 1);
`else
        check("mis_pulse", 32'(misalign), 0);
`endif
        check_req("mis_kill", 0, 0);
        tick; check("mis_clear", 32'(misalign), 0); check_req("mis_req", 1, mis_tgt);
        tick; tick; check_out("mis_out", 1, mis_tgt);

        // PC wrap
        jump_en = 1'b1; jump_addr = 32'hFFFF_FFFC;
        tick; jump_en = 1'b0;
        tick; check_req("req_top", 1, 32'hFFFF_FFFC);
        tick; tick; check_out("out_top", 1, 32'hFFFF_FFFC); check_req("wrap0", 1, 32'h0);

        // reset mid-transaction; the late response must be ignored
        rlat = 2;
        tick; rst = 1'b1;
        tick; rst = 1'b0; rlat = 0;
        check_req("rst2", 0, 0); check_out("rst2_out", 0, 0);
        tick; check_req("rst2_req", 1, 32'h0);
        tick; check_out("late_ignored", 0, 0); check_req("rst2_wait", 0, 0);
        tick; check_out("rst2_out0", 1, 32'h0);

        check("never_deliver_killed", 32'(bad_deliv), 0);
        check("never_grant_dropped", 32'(bad_gnt), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
